// File: rtl/pc_gen.sv
// pc_gen: registered fetch-address generator with branch/jump/trap targets,
// an EPC register, a circular return-address stack and a HALT state.
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter int              IMM_W     = 16,
    parameter int              INDEX_W   = 26,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0180,
    parameter int              RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             br_taken,
    input  logic [IMM_W-1:0] br_imm,
    input  logic             jmp,
    input  logic [INDEX_W-1:0] jmp_index,
    input  logic             jr,
    input  logic [XLEN-1:0]  jr_target,
    input  logic             call,
    input  logic             ret,
    input  logic             trap,
    input  logic             eret,
    input  logic             halt,
    input  logic             resume,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic [XLEN-1:0]  epc,
    output logic             halted,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);
    localparam logic [XLEN-1:0] JMASK = {XLEN{1'b1}} << (INDEX_W + 2);

    typedef enum logic {RUN, HALT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic            push, pop;
    logic [XLEN-1:0] top, jt, bt, jrt;

    assign pc_plus4  = pc_q + XLEN'(4);
    assign ras_empty = cnt_q == '0;
    assign ras_full  = cnt_q == CW'(RAS_DEPTH);
    // ptr_q points at the next free slot, so the newest entry sits just below it
    assign top = ras_q[ptr_q - PW'(1)] & ALIGN;
    assign jrt = jr_target & ALIGN;
    assign jt  = (pc_q & JMASK) | (XLEN'(jmp_index) << 2);
    assign bt  = pc_plus4 + (XLEN'($signed(br_imm)) << 2);

    always_ff @(posedge clk) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        unf_d   = unf_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (en) begin
            if (state_q == HALT) begin
                if (trap) begin
                    epc_d   = pc_q;
                    pc_d    = TRAP_VEC;
                    state_d = RUN;
                end else if (resume) begin
                    pc_d    = pc_plus4;
                    state_d = RUN;
                end
            end else if (trap) begin
                epc_d = pc_q;
                pc_d  = TRAP_VEC;
            end else if (eret) begin
                pc_d = epc_q;
            end else if (halt) begin
                state_d = HALT;
            end else if (jr && ret) begin
                pc_d  = ras_empty ? jrt : top;
                pop   = !ras_empty;
                unf_d = unf_q | ras_empty;
            end else if (jr) begin
                pc_d = jrt;
                push = call;
            end else if (jmp) begin
                pc_d = jt;
                push = call;
            end else begin
                pc_d = br_taken ? bt : pc_plus4;
            end
        end
    end

    // a push into a full stack overwrites the oldest entry
    always_comb begin
        ras_d = ras_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q | (push && ras_full);
        if (push) begin
            ras_d[ptr_q] = pc_plus4;
            ptr_d        = ptr_q + PW'(1);
            cnt_d        = ras_full ? cnt_q : cnt_q + CW'(1);
        end else if (pop) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q  <= RESET_VEC;
            epc_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) ras_q <= ras_d;

    assign pc      = pc_q;
    assign epc     = epc_q;
    assign ras_ovf = ovf_q;
    assign ras_unf = unf_q;
    assign halted  = state_q == HALT;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vectors for pc_gen; the driver queues hand-computed
// expected state per cycle and a monitor compares after each clock edge.
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rst, en, br_taken, jmp, jr, call, ret, trap, eret, halt, resume;
    logic [15:0] br_imm;
    logic [25:0] jmp_index;
    logic [31:0] jr_target;
    logic [31:0] pc, pc_plus4, epc;
    logic        halted, ras_empty, ras_full, ras_ovf, ras_unf;

    typedef struct {
        string       name;
        logic [31:0] pc, epc;
        logic        h, emp, full, ovf, unf;
    } exp_t;

    exp_t        q[$];
    exp_t        m;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] e_pc, e_epc;
    logic        e_h, e_emp, e_full, e_ovf, e_unf;

    pc_gen dut (
        .clk(clk), .rst(rst), .en(en), .br_taken(br_taken), .br_imm(br_imm),
        .jmp(jmp), .jmp_index(jmp_index), .jr(jr), .jr_target(jr_target),
        .call(call), .ret(ret), .trap(trap), .eret(eret), .halt(halt),
        .resume(resume), .pc(pc), .pc_plus4(pc_plus4), .epc(epc),
        .halted(halted), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            m = q.pop_front();
            checks++;
            if ({pc, pc_plus4, epc, halted, ras_empty, ras_full, ras_ovf, ras_unf} !==
                {m.pc, m.pc + 32'd4, m.epc, m.h, m.emp, m.full, m.ovf, m.unf}) begin
                errors++;
                $display("FAIL %s: got pc=%h p4=%h epc=%h h=%b e=%b f=%b o=%b u=%b, want pc=%h p4=%h epc=%h h=%b e=%b f=%b o=%b u=%b",
                         m.name, pc, pc_plus4, epc, halted, ras_empty, ras_full, ras_ovf, ras_unf,
                         m.pc, m.pc + 32'd4, m.epc, m.h, m.emp, m.full, m.ovf, m.unf);
            end
        end
    end

    task automatic clr();
        en = 1; br_taken = 0; br_imm = '0; jmp = 0; jmp_index = '0; jr = 0;
        jr_target = '0; call = 0; ret = 0; trap = 0; eret = 0; halt = 0; resume = 0;
    endtask

    task automatic cyc(input string n);
        q.push_back('{n, e_pc, e_epc, e_h, e_emp, e_full, e_ovf, e_unf});
        @(posedge clk);
        #2;
    endtask

    task automatic jump_to(input logic [25:0] idx, input logic [31:0] p, input string n);
        clr(); jmp = 1; jmp_index = idx; e_pc = p; cyc(n); clr();
    endtask

    initial begin
        clr(); rst = 0;
        e_pc = 0; e_epc = 0; e_h = 0; e_emp = 1; e_full = 0; e_ovf = 0; e_unf = 0;
        cyc("reset");
        rst = 1;
        e_pc = 32'd4;  cyc("seq4");
        e_pc = 32'd8;  cyc("seq8");
        e_pc = 32'd12; cyc("seq12");
        rst = 0; e_pc = 0; cyc("reset_midrun");
        rst = 1;

        jump_to(26'h40, 32'h100, "jmp_0x100");
        br_taken = 1; br_imm = 16'hFFFE; en = 0; e_pc = 32'h100; cyc("branch_stalled");
        en = 1; e_pc = 32'hFC; cyc("branch_negative");
        jump_to(26'h40, 32'h100, "jmp_0x100_again");
        br_taken = 1; br_imm = 16'd3; e_pc = 32'h110; cyc("branch_positive");
        clr();

        jr = 1; jr_target = 32'h1000_0040; e_pc = 32'h1000_0040; cyc("jr_high");
        jump_to(26'h10, 32'h1000_0040, "jmp_keeps_upper");
        jr = 1; jr_target = 32'h2003; e_pc = 32'h2000; cyc("jr_aligned");
        clr();

        jump_to(26'h4, 32'h10, "jmp_0x10");
        for (int i = 0; i < 5; i++) begin
            jmp = 1; call = 1; jmp_index = 26'((i + 2) * 4);
            e_pc = 32'((i + 2) * 16); e_emp = 0; e_full = (i >= 3); e_ovf = (i >= 4);
            cyc($sformatf("call%0d", i));
        end
        clr();
        // stack now holds 0x24,0x34,0x44,0x54; call alongside ret must not push
        for (int k = 0; k < 4; k++) begin
            jr = 1; ret = 1; call = (k == 0); jr_target = 32'h3000;
            e_pc = 32'h54 - 32'(k * 16); e_full = 0; e_emp = (k == 3);
            cyc($sformatf("ret%0d", k));
        end
        call = 0; e_pc = 32'h3000; e_unf = 1; cyc("ret_underflow");
        clr();

        jump_to(26'h80, 32'h200, "jmp_0x200");
        trap = 1; jr = 1; jr_target = 32'h5000; e_pc = 32'h180; e_epc = 32'h200; cyc("trap_beats_jr");
        clr(); eret = 1; e_pc = 32'h200; cyc("eret");
        clr(); e_pc = 32'h204; cyc("seq_after_eret");

        jump_to(26'h10, 32'h40, "jmp_0x40");
        halt = 1; e_h = 1; cyc("halt");
        clr();
        for (int i = 0; i < 5; i++) begin
            jmp = 1; jmp_index = 26'h99; br_taken = 1; br_imm = 16'd5; eret = 1;
            cyc($sformatf("halt_hold%0d", i));
        end
        clr(); resume = 1; trap = 1; e_pc = 32'h180; e_epc = 32'h40; e_h = 0; cyc("halt_trap_beats_resume");
        clr(); halt = 1; e_h = 1; cyc("halt_again");
        clr(); en = 0; resume = 1; cyc("halt_stalled");
        en = 1; e_pc = 32'h184; e_h = 0; cyc("resume");
        clr();

        jr = 1; jr_target = 32'hFFFF_FFFF; e_pc = 32'hFFFF_FFFC; cyc("jr_top");
        clr(); e_pc = 32'h0; cyc("pc_wrap");

        rst = 0; trap = 1;
        e_pc = 0; e_epc = 0; e_h = 0; e_emp = 1; e_full = 0; e_ovf = 0; e_unf = 0;
        cyc("reset_clears_sticky");
        rst = 1; clr();

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
